// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and forwarding selects.
package alu_pkg;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_ILL  = 3'b011;
   localparam logic [2:0] ALU_ANDN = 3'b100;
   localparam logic [2:0] ALU_ORN  = 3'b101;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub/logic/slt, zero flag, and illegal-op flag for the reserved code.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alucontrol,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   // Signed compare instead of the sign of a-b, so slt stays right on overflow.
   logic lt;
   assign lt = ($signed(a) < $signed(b));

   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (alucontrol)
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_ADD:  result = a + b;
         ALU_ANDN: result = a & ~b;
         ALU_ORN:  result = a | ~b;
         ALU_SUB:  result = a - b;
         ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt};
         ALU_ILL:  illegal = 1'b1;
         default:  illegal = 1'b1;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ID/EX register with flush, operand forwarding, ALU, and the EX/MEM register.
module exec_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int RW    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flushE,
   input  logic [2:0]       alucontrolD,
   input  logic             regwriteD,
   input  logic             memtoregD,
   input  logic             memwriteD,
   input  logic             alusrcD,
   input  logic             regdstD,
   input  logic [WIDTH-1:0] rd1D,
   input  logic [WIDTH-1:0] rd2D,
   input  logic [WIDTH-1:0] signimmD,
   input  logic [RW-1:0]    rsD,
   input  logic [RW-1:0]    rtD,
   input  logic [RW-1:0]    rdD,
   input  logic [1:0]       forwardAE,
   input  logic [1:0]       forwardBE,
   input  logic [WIDTH-1:0] resultW,
   output logic [RW-1:0]    rsE,
   output logic [RW-1:0]    rtE,
   output logic [RW-1:0]    writeregE,
   output logic             regwriteE,
   output logic             memtoregE,
   output logic [WIDTH-1:0] aluoutM,
   output logic [WIDTH-1:0] writedataM,
   output logic [RW-1:0]    writeregM,
   output logic             regwriteM,
   output logic             memtoregM,
   output logic             memwriteM,
   output logic             zeroM,
   output logic             illegalM
);

   logic [2:0]       alucontrolE;
   logic             memwriteE, alusrcE, regdstE;
   logic [WIDTH-1:0] rd1E, rd2E, signimmE;
   logic [RW-1:0]    rdE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alucontrolE <= '0;
         regwriteE   <= 1'b0;
         memtoregE   <= 1'b0;
         memwriteE   <= 1'b0;
         alusrcE     <= 1'b0;
         regdstE     <= 1'b0;
         rd1E        <= '0;
         rd2E        <= '0;
         signimmE    <= '0;
         rsE         <= '0;
         rtE         <= '0;
         rdE         <= '0;
      end else if (flushE) begin
         alucontrolE <= '0;
         regwriteE   <= 1'b0;
         memtoregE   <= 1'b0;
         memwriteE   <= 1'b0;
         alusrcE     <= 1'b0;
         regdstE     <= 1'b0;
         rd1E        <= '0;
         rd2E        <= '0;
         signimmE    <= '0;
         rsE         <= '0;
         rtE         <= '0;
         rdE         <= '0;
      end else begin
         alucontrolE <= alucontrolD;
         regwriteE   <= regwriteD;
         memtoregE   <= memtoregD;
         memwriteE   <= memwriteD;
         alusrcE     <= alusrcD;
         regdstE     <= regdstD;
         rd1E        <= rd1D;
         rd2E        <= rd2D;
         signimmE    <= signimmD;
         rsE         <= rsD;
         rtE         <= rtD;
         rdE         <= rdD;
      end
   end

   assign writeregE = regdstE ? rdE : rtE;

   // Select 11 is reserved and falls back to the register-file value.
   logic [WIDTH-1:0] srcaE, writedataE, srcbE;
   always_comb begin
      srcaE = rd1E;
      case (forwardAE)
         FWD_WB:  srcaE = resultW;
         FWD_MEM: srcaE = aluoutM;
         default: srcaE = rd1E;
      endcase
      writedataE = rd2E;
      case (forwardBE)
         FWD_WB:  writedataE = resultW;
         FWD_MEM: writedataE = aluoutM;
         default: writedataE = rd2E;
      endcase
   end

   assign srcbE = alusrcE ? signimmE : writedataE;

   logic [WIDTH-1:0] aluoutE;
   logic             zeroE, illegalE;

   alu_core #(.WIDTH(WIDTH)) u_alu (
      .a          (srcaE),
      .b          (srcbE),
      .alucontrol (alucontrolE),
      .result     (aluoutE),
      .zero       (zeroE),
      .illegal    (illegalE)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aluoutM    <= '0;
         writedataM <= '0;
         writeregM  <= '0;
         regwriteM  <= 1'b0;
         memtoregM  <= 1'b0;
         memwriteM  <= 1'b0;
         zeroM      <= 1'b0;
         illegalM   <= 1'b0;
      end else begin
         aluoutM    <= aluoutE;
         writedataM <= writedataE;
         writeregM  <= writeregE;
         regwriteM  <= regwriteE;
         memtoregM  <= memtoregE;
         memwriteM  <= memwriteE;
         zeroM      <= zeroE;
         illegalM   <= illegalE;
      end
   end

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: each issued bundle pushes its expected E/M view, popped when it reaches M.
module tb_exec_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        flushE;
   logic [2:0]  alucontrolD;
   logic        regwriteD, memtoregD, memwriteD, alusrcD, regdstD;
   logic [31:0] rd1D, rd2D, signimmD, resultW;
   logic [4:0]  rsD, rtD, rdD;
   logic [1:0]  forwardAE, forwardBE;
   logic [4:0]  rsE, rtE, writeregE, writeregM;
   logic        regwriteE, memtoregE;
   logic [31:0] aluoutM, writedataM;
   logic        regwriteM, memtoregM, memwriteM, zeroM, illegalM;

   exec_stage #(.WIDTH(32), .RW(5)) dut (
      .clk(clk), .reset(reset), .flushE(flushE), .alucontrolD(alucontrolD),
      .regwriteD(regwriteD), .memtoregD(memtoregD), .memwriteD(memwriteD),
      .alusrcD(alusrcD), .regdstD(regdstD), .rd1D(rd1D), .rd2D(rd2D),
      .signimmD(signimmD), .rsD(rsD), .rtD(rtD), .rdD(rdD),
      .forwardAE(forwardAE), .forwardBE(forwardBE), .resultW(resultW),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
      .memtoregE(memtoregE), .aluoutM(aluoutM), .writedataM(writedataM),
      .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
      .memwriteM(memwriteM), .zeroM(zeroM), .illegalM(illegalM)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic [2:0]  op;
      logic        rw, m2r, mw, asrc, rdst;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
      logic [1:0]  fa, fb;    // forwarding applied while this bundle sits in E
      logic [31:0] resw;
   } instr_t;

   typedef struct {
      logic [31:0] alu, wd;
      logic [4:0]  wreg, rs, rt;
      logic        rw, m2r, mw, zero, ill;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] prev_alu = '0;
   logic [1:0]  pend_fa = '0, pend_fb = '0;
   logic [31:0] pend_resw = '0;

   function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b100:  return a & ~b;
         3'b101:  return a | ~b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic instr_t mk(input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2);
      instr_t i;
      i = '{flush: 1'b0, op: op, rw: 1'b1, m2r: 1'b0, mw: 1'b0, asrc: 1'b0, rdst: 1'b1,
            rd1: rd1, rd2: rd2, imm: 32'd0, rs: 5'd1, rt: 5'd2, rd: 5'd3,
            fa: 2'b00, fb: 2'b00, resw: 32'd0};
      return i;
   endfunction

   task automatic issue(input instr_t in);
      exp_t        e, m;
      logic [31:0] r1, r2, im, a, b, sb;
      logic [2:0]  op;
      logic        z;
      flushE = in.flush; alucontrolD = in.op; regwriteD = in.rw; memtoregD = in.m2r;
      memwriteD = in.mw; alusrcD = in.asrc; regdstD = in.rdst;
      rd1D = in.rd1; rd2D = in.rd2; signimmD = in.imm; rsD = in.rs; rtD = in.rt; rdD = in.rd;
      forwardAE = pend_fa; forwardBE = pend_fb; resultW = pend_resw;
      z  = in.flush;
      r1 = z ? 32'd0 : in.rd1;
      r2 = z ? 32'd0 : in.rd2;
      im = z ? 32'd0 : in.imm;
      op = z ? 3'b000 : in.op;
      a  = (in.fa == 2'b01) ? in.resw : (in.fa == 2'b10) ? prev_alu : r1;
      b  = (in.fb == 2'b01) ? in.resw : (in.fb == 2'b10) ? prev_alu : r2;
      sb = (!z && in.asrc) ? im : b;
      e.alu  = model_alu(op, a, sb);
      e.ill  = (op == 3'b011);
      e.zero = (e.alu == 32'd0);
      e.wd   = b;
      e.rs   = z ? 5'd0 : in.rs;
      e.rt   = z ? 5'd0 : in.rt;
      e.wreg = z ? 5'd0 : (in.rdst ? in.rd : in.rt);
      e.rw   = z ? 1'b0 : in.rw;
      e.m2r  = z ? 1'b0 : in.m2r;
      e.mw   = z ? 1'b0 : in.mw;
      q.push_back(e);
      prev_alu = e.alu; pend_fa = in.fa; pend_fb = in.fb; pend_resw = in.resw;
      @(posedge clk); #1;
      checks++;
      if ({rsE, rtE, writeregE, regwriteE, memtoregE} !== {e.rs, e.rt, e.wreg, e.rw, e.m2r}) begin
         errors++;
         $display("FAIL e_fields: got rs=%0d rt=%0d wreg=%0d rw=%b m2r=%b want rs=%0d rt=%0d wreg=%0d rw=%b m2r=%b",
                  rsE, rtE, writeregE, regwriteE, memtoregE, e.rs, e.rt, e.wreg, e.rw, e.m2r);
      end
      if (q.size() >= 2) begin
         m = q.pop_front();
         checks++;
         if (aluoutM !== m.alu) begin
            errors++;
            $display("FAIL aluoutM: got %h want %h", aluoutM, m.alu);
         end
         checks++;
         if (writedataM !== m.wd) begin
            errors++;
            $display("FAIL writedataM: got %h want %h", writedataM, m.wd);
         end
         checks++;
         if ({writeregM, regwriteM, memtoregM, memwriteM, zeroM, illegalM} !== {m.wreg, m.rw, m.m2r, m.mw, m.zero, m.ill}) begin
            errors++;
            $display("FAIL m_ctrl: got wreg=%0d rw=%b m2r=%b mw=%b z=%b ill=%b want wreg=%0d rw=%b m2r=%b mw=%b z=%b ill=%b",
                     writeregM, regwriteM, memtoregM, memwriteM, zeroM, illegalM,
                     m.wreg, m.rw, m.m2r, m.mw, m.zero, m.ill);
         end
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({rsE, rtE, writeregE, regwriteE, memtoregE, aluoutM, writedataM, writeregM,
           regwriteM, memtoregM, memwriteM, zeroM, illegalM} !== '0) begin
         errors++;
         $display("FAIL %s: got aluoutM=%h wdM=%h wregM=%0d rwM=%b mwM=%b zM=%b illM=%b rwE=%b wregE=%0d want all 0",
                  name, aluoutM, writedataM, writeregM, regwriteM, memwriteM, zeroM, illegalM, regwriteE, writeregE);
      end
   endtask

   task automatic clear_model();
      q.delete();
      prev_alu = '0; pend_fa = '0; pend_fb = '0; pend_resw = '0;
   endtask

   task automatic test_reset();
      instr_t i;
      reset = 1'b0; flushE = 0; alucontrolD = 3'b010; regwriteD = 1; memtoregD = 1; memwriteD = 1;
      alusrcD = 0; regdstD = 1; rd1D = 32'h11; rd2D = 32'h22; signimmD = 0;
      rsD = 5'd4; rtD = 5'd5; rdD = 5'd6; forwardAE = 0; forwardBE = 0; resultW = 0;
      #12;
      check_all_zero("reset_initial");
      reset = 1'b1;
      clear_model();
      issue(mk(3'b010, 32'd10, 32'd20));
      issue(mk(3'b001, 32'hF0, 32'h0F));
      issue(mk(3'b010, 32'd1, 32'd2));
      #2 reset = 1'b0;
      #1 check_all_zero("reset_async");
      clear_model();
      @(posedge clk); #3 reset = 1'b1;
      i = mk(3'b010, 32'd100, 32'd23);
      i.rd = 5'd9;
      issue(i);
      issue(mk(3'b110, 32'd50, 32'd8));
   endtask

   task automatic test_arith();
      instr_t i;
      issue(mk(3'b010, 32'h7FFFFFFF, 32'd1));
      issue(mk(3'b110, 32'h7FFFFFFF, 32'd1));
      issue(mk(3'b111, 32'hFFFFFFFF, 32'd1));
      issue(mk(3'b111, 32'h7FFFFFFF, 32'h80000000));
      issue(mk(3'b110, 32'd5, 32'd5));
      issue(mk(3'b100, 32'hFF00FF00, 32'h0F0F0F0F));
      i = mk(3'b101, 32'h0, 32'hFFFF0000);
      i.rdst = 1'b0;
      issue(i);
   endtask

   task automatic test_imm_store();
      instr_t i;
      i = mk(3'b010, 32'h100, 32'hABCD);
      i.asrc = 1; i.imm = 32'hFFFFFFFC; i.mw = 1; i.rw = 0; i.rdst = 0; i.rt = 5'd7;
      issue(i);
      i = mk(3'b010, 32'h200, 32'h1234);
      i.m2r = 1; i.asrc = 1; i.imm = 32'd8; i.rdst = 0; i.rt = 5'd12;
      issue(i);
   endtask

   task automatic test_forward();
      instr_t i;
      issue(mk(3'b010, 32'd3, 32'd4));
      i = mk(3'b010, 32'h1000, 32'd1); i.fa = 2'b10;
      issue(i);
      i = mk(3'b010, 32'd2, 32'h9999); i.fb = 2'b01; i.resw = 32'h55;
      issue(i);
      i = mk(3'b010, 32'd9, 32'd1); i.fa = 2'b11; i.fb = 2'b11; i.resw = 32'hDEAD;
      issue(i);
      i = mk(3'b001, 32'd0, 32'd0); i.fb = 2'b10; i.mw = 1;
      issue(i);
   endtask

   task automatic test_flush_illegal();
      instr_t i;
      i = mk(3'b010, 32'h1234, 32'h5678);
      i.flush = 1; i.mw = 1; i.rw = 1;
      issue(i);
      issue(mk(3'b011, 32'h1234, 32'h5678));
      issue(mk(3'b010, 32'd1, 32'd1));
   endtask

   task automatic test_back_to_back();
      instr_t i;
      for (int n = 0; n < 40; n++) begin
         i.flush = ($urandom_range(0, 7) == 0);
         i.op = 3'($urandom); i.rw = 1'($urandom); i.m2r = 1'($urandom); i.mw = 1'($urandom);
         i.asrc = 1'($urandom); i.rdst = 1'($urandom);
         i.rd1 = $urandom; i.rd2 = $urandom; i.imm = $urandom;
         i.rs = 5'($urandom); i.rt = 5'($urandom); i.rd = 5'($urandom);
         i.fa = 2'($urandom); i.fb = 2'($urandom); i.resw = $urandom;
         issue(i);
      end
   endtask

   initial begin
      instr_t bub;
      test_reset();
      test_arith();
      test_imm_store();
      test_forward();
      test_flush_illegal();
      test_back_to_back();
      bub = mk(3'b000, 32'd0, 32'd0);
      bub.flush = 1;
      issue(bub);
      issue(bub);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
